// File: rtl/fifo_rd_adapter.sv
// Read-side consumer for sync_fifo: hides the 1-cycle registered read latency
// and presents words on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_adapter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] rd_count
);

  logic [WIDTH-1:0] data_buf [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             inflight;
  logic             drop;
  logic             pop;
  logic             capture;
  logic [2:0]       pending;

  // A read is only issued when the word it returns is guaranteed a free slot,
  // counting words already in flight and the slot freed by this cycle's pop.
  always_comb begin
    m_valid    = (occ != 2'd0) && !flush;
    m_data     = data_buf[rd_ptr];
    pop        = m_valid && m_ready;
    capture    = inflight && !drop && !flush;
    pending    = 3'(occ) + 3'(inflight) - 3'(pop);
    fifo_rd_en = rst_n && en && !flush && !fifo_empty && (pending < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_buf[0] <= '0;
      data_buf[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      inflight    <= 1'b0;
      drop        <= 1'b0;
      rd_count    <= '0;
    end else if (flush) begin
      // An in-flight word would land after the flush; drop marks it for discard.
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      drop     <= inflight;
    end else begin
      if (capture) begin
        data_buf[wr_ptr] <= fifo_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        rd_count <= rd_count + CNT_W'(1);
      end
      occ      <= occ + 2'(capture) - 2'(pop);
      inflight <= fifo_rd_en;
      drop     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: a queue-based sync_fifo model feeds the DUT and a
// scoreboard of outstanding words predicts valid/data/rd_en/count every cycle.
module tb_fifo_rd_adapter;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [CNT_W-1:0] rd_count;

  fifo_rd_adapter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               rdy;
  } pend_t;

  pend_t            exp_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] delivered[$];
  int               deliv_cyc[$];
  int               rd_cyc[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               model_count = 0;
  int               rd_issued = 0;
  logic             fifo_pop = 1'b0;
  logic             exp_valid, exp_pop, exp_rd;
  pend_t            tmp;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Registered-read FIFO model; the read decision is latched mid-cycle.
  always @(posedge clk) begin
    if (fifo_pop && fifo_q.size() > 0) begin
      fifo_dout  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Reference model: every word read from the FIFO is outstanding until it is
  // handed downstream, becomes visible 2 cycles after its read, and at most 2
  // may be outstanding. Flush and reset discard all outstanding words.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_m_valid", 32'(m_valid), 0);
      checkOutput("rst_rd_count", 32'(rd_count), 0);
      checkOutput("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
      checkOutput("rst_m_data", 32'(m_data), 0);
      exp_q.delete();
      model_count = 0;
      fifo_pop = 1'b0;
    end else begin
      exp_valid = !flush && exp_q.size() > 0 && exp_q[0].rdy <= cyc;
      exp_pop   = exp_valid && m_ready;
      exp_rd    = en && !flush && !fifo_empty && (exp_q.size() - int'(exp_pop)) < 2;
      checkOutput("m_valid", 32'(m_valid), 32'(exp_valid));
      checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      checkOutput("rd_count", 32'(rd_count), 32'(model_count % (1 << CNT_W)));
      if (exp_valid) checkOutput("m_data", 32'(m_data), 32'(exp_q[0].data));
      fifo_pop = fifo_rd_en;
      if (fifo_rd_en) begin
        rd_issued++;
        rd_cyc.push_back(cyc);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_pop) begin
          tmp = exp_q.pop_front();
          delivered.push_back(tmp.data);
          deliv_cyc.push_back(cyc);
          model_count++;
        end
        if (exp_rd && fifo_q.size() > 0) begin
          tmp.data = fifo_q[0];
          tmp.rdy  = cyc + 2;
          exp_q.push_back(tmp);
        end
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clearLogs();
    delivered.delete();
    deliv_cyc.delete();
    rd_cyc.delete();
    rd_issued = 0;
  endtask

  task automatic resetDut();
    rst_n   = 1'b0;
    en      = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    tick(2);
    rst_n = 1'b1;
    clearLogs();
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0 && fifo_q.size() < 16) pushWord(8'($urandom_range(0, 255)));
      m_ready = ($urandom_range(0, 3) != 0);
      en      = ($urandom_range(0, 7) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      tick(1);
    end
    flush = 1'b0;
  endtask

  initial begin
    tick(3);
    resetDut();
    checkOutput("post_reset_m_valid", 32'(m_valid), 0);
    checkOutput("post_reset_rd_count", 32'(rd_count), 0);

    // Single word: 2-cycle latency, one read only.
    m_ready = 1'b1;
    en      = 1'b1;
    pushWord(8'hAA);
    tick(6);
    checkOutput("single_count", 32'(delivered.size()), 1);
    if (delivered.size() == 1) begin
      checkOutput("single_data", 32'(delivered[0]), 32'hAA);
      checkOutput("single_latency", 32'(deliv_cyc[0] - rd_cyc[0]), 2);
    end
    checkOutput("single_rd_count", 32'(rd_count), 1);
    checkOutput("single_rd_issued", 32'(rd_issued), 1);

    // Streaming 0..7 at one word per cycle.
    resetDut();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) pushWord(8'(i));
    en = 1'b1;
    tick(14);
    checkOutput("stream_count", 32'(delivered.size()), 8);
    if (delivered.size() == 8)
      for (int i = 0; i < 8; i++) begin
        checkOutput("stream_data", 32'(delivered[i]), 32'(i));
        checkOutput("stream_gapless", 32'(deliv_cyc[i] - deliv_cyc[0]), 32'(i));
      end
    checkOutput("stream_rd_count", 32'(rd_count), 8);
    checkOutput("stream_idle", 32'(m_valid), 0);

    // Backpressure: only two reads, head held, then gapless drain.
    resetDut();
    for (int i = 0; i < 8; i++) pushWord(8'(i));
    en = 1'b1;
    tick(10);
    checkOutput("bp_rd_issued", 32'(rd_issued), 2);
    checkOutput("bp_m_valid", 32'(m_valid), 1);
    checkOutput("bp_m_data", 32'(m_data), 0);
    m_ready = 1'b1;
    tick(12);
    checkOutput("bp_count", 32'(delivered.size()), 8);
    if (delivered.size() == 8)
      for (int i = 0; i < 8; i++) begin
        checkOutput("bp_data", 32'(delivered[i]), 32'(i));
        checkOutput("bp_gapless", 32'(deliv_cyc[i] - deliv_cyc[0]), 32'(i));
      end
    checkOutput("bp_fifo_empty", 32'(fifo_empty), 1);

    // Flush with one word buffered and one in flight.
    resetDut();
    pushWord(8'h0F);
    pushWord(8'h11);
    en = 1'b1;
    tick(2);
    checkOutput("flush_pre_valid", 32'(m_valid), 1);
    flush = 1'b1;
    #1;
    checkOutput("flush_m_valid", 32'(m_valid), 0);
    checkOutput("flush_rd_en", 32'(fifo_rd_en), 0);
    tick(1);
    flush = 1'b0;
    checkOutput("flush_rd_count", 32'(rd_count), 0);
    pushWord(8'h22);
    m_ready = 1'b1;
    tick(6);
    checkOutput("flush_count", 32'(delivered.size()), 1);
    if (delivered.size() == 1) checkOutput("flush_data", 32'(delivered[0]), 32'h22);
    checkOutput("flush_rd_count_after", 32'(rd_count), 1);

    // en gating, then 18 words wrap a 4-bit counter to 2.
    resetDut();
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) pushWord(8'(i * 3 + 1));
    tick(10);
    checkOutput("en_gate_rd_issued", 32'(rd_issued), 0);
    en = 1'b1;
    tick(25);
    checkOutput("wrap_count", 32'(delivered.size()), 18);
    checkOutput("wrap_rd_count", 32'(rd_count), 2);

    // Asynchronous reset while the buffer is full.
    resetDut();
    m_ready = 1'b1;
    en      = 1'b1;
    for (int i = 0; i < 10; i++) pushWord(8'(8'h30 + i));
    tick(4);
    m_ready = 1'b0;
    tick(4);
    checkOutput("mid_pre_valid", 32'(m_valid), 1);
    checkOutput("mid_pre_rd_count", 32'(rd_count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_m_valid", 32'(m_valid), 0);
    checkOutput("mid_rst_rd_count", 32'(rd_count), 0);
    checkOutput("mid_rst_rd_en", 32'(fifo_rd_en), 0);
    fifo_q.delete();
    fifo_empty = 1'b1;
    tick(2);
    rst_n = 1'b1;
    clearLogs();
    for (int i = 0; i < 3; i++) pushWord(8'(8'h50 + i));
    m_ready = 1'b1;
    tick(8);
    checkOutput("resume_count", 32'(delivered.size()), 3);
    if (delivered.size() == 3)
      for (int i = 0; i < 3; i++) checkOutput("resume_data", 32'(delivered[i]), 32'(8'h50 + i));
    checkOutput("resume_rd_count", 32'(rd_count), 3);

    // Randomized traffic, then drain.
    resetDut();
    applyStimulus(600);
    en      = 1'b1;
    m_ready = 1'b1;
    tick(40);
    checkOutput("drain_fifo_left", 32'(fifo_q.size()), 0);
    checkOutput("drain_m_valid", 32'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_rd_adapter.md
Name: fifo_rd_adapter

Overview:
Read-side consumer for a sync_fifo instance. It drives the FIFO read port (rd_en, dout, empty) and hides the FIFO's 1-cycle registered read latency. It presents words downstream on a valid/ready stream through a 2-entry output buffer, sustaining 1 word/cycle with no overrun under backpressure. It sits between sync_fifo and any stream consumer (serializer, packet builder).

Parameters:
WIDTH, 8, data word width; must match the sync_fifo WIDTH.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset
en  input  1  permit new FIFO reads; buffered words still drain when low
flush  input  1  discard buffered and in-flight words (single-cycle pulse or level)
fifo_empty  input  1  sync_fifo empty flag
fifo_dout  input  WIDTH  sync_fifo read data, valid the cycle after an accepted rd_en
fifo_rd_en  output  1  sync_fifo read enable (combinational)
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts word
m_data  output  WIDTH  output word (head of buffer)
rd_count  output  CNT_W  number of completed m_valid&&m_ready handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset: one clock, clk; rst_n asynchronous, active-low. While rst_n=0: occupancy=0, inflight=0, drop=0, m_valid=0, m_data=0, rd_count=0, fifo_rd_en=0.
- State: 2-entry circular buffer (wr_ptr, rd_ptr 1 bit each, occ 0..2), inflight flag (1 bit), drop flag (1 bit).
- pop = m_valid && m_ready && !flush.
- fifo_rd_en = en && !flush && !fifo_empty && (occ + inflight - pop) < 2. Evaluated combinationally each cycle.
- Read latency: fifo_rd_en high in cycle N gives inflight=1 after edge N+1, with fifo_dout valid during cycle N+1. The word is written to buffer[wr_ptr] at edge N+2, and m_valid is high from edge N+2. This is 2 cycles from rd_en to m_valid.
- inflight is set at edge N+1 and cleared at edge N+2 unless another read is issued in cycle N+1. With back-to-back reads inflight stays 1.
- m_valid = (occ != 0) && !flush. m_data = buffer[rd_ptr]. m_data must hold stable while m_valid && !m_ready.
- Pop and capture may occur on the same edge: occ stays unchanged and both pointers advance.
- Throughput: with m_ready held 1 and the FIFO non-empty, exactly 1 word per cycle in steady state.
- Backpressure: occ + inflight never exceeds 2. No word is ever written into a full buffer.
- Ordering: words leave in exact FIFO order. No duplication, no loss except under flush.
- flush cycle: fifo_rd_en=0 and m_valid=0, so no handshake occurs. At the edge, occ=0 and pointers reset to 0. If inflight=1, drop is set, and the arriving word on the next edge is discarded without being written; drop then clears. rd_count is unchanged by flush.
- en low: no new reads. An in-flight word is still captured, and the buffer drains normally.
- FIFO goes empty after the last read: fifo_rd_en drops on its own. The pending in-flight word is still delivered.
- Reset mid-operation: all state clears immediately (asynchronous). Buffered and in-flight words are lost. The FIFO is expected to be reset alongside.
- rd_count increments by 1 per pop and wraps from 2^CNT_W-1 to 0.

Test Plan:
- Single word: FIFO holds 0xAA, en=1, m_ready=1 -> fifo_rd_en pulses 1 cycle; m_valid high 2 cycles later with m_data=0xAA; rd_count=1; fifo_rd_en stays 0 afterwards.
- Streaming: FIFO preloaded 0..7, m_ready=1 -> m_data shows 0,1,...,7 on 8 consecutive cycles; rd_count=8; m_valid low afterwards.
- Backpressure: FIFO holds 0..7, m_ready=0 -> exactly 2 reads issued, m_data=0 held stable. Then m_ready=1 -> 0..7 delivered in order with no gaps after refill; FIFO ends empty.
- Flush with inflight: issue a read of 0x11 with buffer holding 0x0F, assert flush for 1 cycle in the inflight cycle -> neither 0x0F nor 0x11 appears; next FIFO word 0x22 is delivered normally; rd_count unchanged by flush.
- en gating plus wrap: with en=0 and a non-empty FIFO, fifo_rd_en stays 0 for 10 cycles. Then set en=1 with CNT_W=4 and stream 18 words -> rd_count=2.
- Reset mid-stream: assert rst_n=0 between edges while occ=2 -> m_valid, rd_count and fifo_rd_en go 0 immediately, without waiting for a clock edge; normal operation resumes after release.
